lcb_responder: RTL and testbench

LCB-side responder for the RS-485 request/answer link driven by the central telemetry frame builder. It receives a fixed-length 8N1 request on `rx` and checks the device address and checksum. It then turns the bus around, reads answer bytes from a local sample store, and transmits them with a trailing checksum. It sits in the LCB FPGA between the RS-485 transceiver and the sample memory.

---
 rtl/lcb_responder.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_lcb_responder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcb_responder.sv
// LCB-side RS-485 responder: receives a 4-byte 8N1 request, validates address and
// checksum, then answers with ANS_BYTES samples from the local store plus an XOR checksum.
module lcb_responder #(
   parameter int BIT_CYCLES     = 16,
   parameter int ANS_BYTES      = 2,
   parameter int TURN_CYCLES    = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   input  logic [7:0] myAddr,
   input  logic [7:0] rdData,
   output logic       tx,
   output logic       dirTX,
   output logic       dirRX,
   output logic [7:0] rdAddr,
   output logic       reqValid,
   output logic [7:0] reqCmd,
   output logic       errFlag,
   output logic       busy
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_RXCOL = 3'd1;
   localparam logic [2:0] S_CHECK = 3'd2;
   localparam logic [2:0] S_TURN  = 3'd3;
   localparam logic [2:0] S_PRE   = 3'd4;
   localparam logic [2:0] S_LOAD  = 3'd5;
   localparam logic [2:0] S_SHIFT = 3'd6;
   localparam logic [2:0] S_POST  = 3'd7;

   localparam int TMAX0 = (TIMEOUT_CYCLES > TURN_CYCLES) ? TIMEOUT_CYCLES : TURN_CYCLES;
   localparam int TMAX  = (TMAX0 > BIT_CYCLES) ? TMAX0 : BIT_CYCLES;
   localparam int TW    = $clog2(TMAX + 1);
   localparam int BW    = $clog2(BIT_CYCLES + 1);

   localparam logic [TW-1:0] T_TO   = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] T_TURN = TW'(TURN_CYCLES - 1);
   localparam logic [TW-1:0] T_BIT  = TW'(BIT_CYCLES - 1);
   localparam logic [TW-1:0] T_LOAD = TW'(2);
   localparam logic [TW-1:0] T_ONE  = TW'(1);
   localparam logic [BW-1:0] B_HALF = BW'(BIT_CYCLES / 2);
   localparam logic [BW-1:0] B_LAST = BW'(BIT_CYCLES - 1);
   localparam logic [BW-1:0] B_ONE  = BW'(1);
   localparam logic [4:0]    K_LAST = 5'(ANS_BYTES);

   // rx synchroniser plus one extra stage for falling-edge detection
   logic rx_m_q, rx_s_q, rx_p_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_m_q <= 1'b1;
         rx_s_q <= 1'b1;
         rx_p_q <= 1'b1;
      end else begin
         rx_m_q <= rx;
         rx_s_q <= rx_m_q;
         rx_p_q <= rx_s_q;
      end
   end

   logic [2:0]    state_q, state_d;
   logic          busy_q, busy_d;
   logic          rcv_q;
   logic [BW-1:0] rcyc_q;
   logic [3:0]    rbit_q;
   logic [7:0]    rsh_q;

   logic fall, rcv_en, samp, byte_done;
   assign fall      = rx_p_q & ~rx_s_q;
   assign rcv_en    = ~busy_q & ((state_q == S_IDLE) | (state_q == S_RXCOL));
   assign samp      = rcv_q & (rcyc_q == B_HALF);
   assign byte_done = samp & (rbit_q == 4'd9);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rcv_q  <= 1'b0;
         rcyc_q <= '0;
         rbit_q <= '0;
         rsh_q  <= '0;
      end else if (!rcv_en) begin
         rcv_q <= 1'b0;
      end else if (!rcv_q) begin
         if (fall) begin
            rcv_q  <= 1'b1;
            rcyc_q <= B_ONE;
            rbit_q <= '0;
         end
      end else begin
         rcyc_q <= (rcyc_q == B_LAST) ? '0 : rcyc_q + B_ONE;
         if (samp) begin
            rbit_q <= rbit_q + 4'd1;
            // a start bit that reads high at mid-bit was a glitch
            if ((rbit_q == 4'd0 && rx_s_q) || rbit_q == 4'd9) rcv_q <= 1'b0;
            else if (rbit_q != 4'd0) rsh_q <= {rx_s_q, rsh_q[7:1]};
         end
      end
   end

   logic [1:0]    cnt_q, cnt_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [7:0]    b0_q, b0_d, b1_q, b1_d, b2_q, b2_d, b3_q, b3_d;
   logic          ferr_q, ferr_d;
   logic [4:0]    k_q, k_d;
   logic [7:0]    ck_q, ck_d;
   logic [8:0]    sh_q, sh_d;
   logic [3:0]    nb_q, nb_d;
   logic          tx_q, tx_d, dir_q, dir_d;
   logic [7:0]    rdaddr_q, rdaddr_d, cmd_q, cmd_d;
   logic          rv_q, rv_d, err_q, err_d;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      tmr_d    = tmr_q;
      b0_d     = b0_q;
      b1_d     = b1_q;
      b2_d     = b2_q;
      b3_d     = b3_q;
      ferr_d   = ferr_q;
      k_d      = k_q;
      ck_d     = ck_q;
      sh_d     = sh_q;
      nb_d     = nb_q;
      tx_d     = tx_q;
      dir_d    = dir_q;
      busy_d   = busy_q;
      rdaddr_d = rdaddr_q;
      cmd_d    = cmd_q;
      rv_d     = 1'b0;
      err_d    = 1'b0;
      case (state_q)
         S_IDLE, S_RXCOL: begin
            // inter-byte timeout wins over a start edge in the same clk
            if (cnt_q != 2'd0 && !rcv_q && tmr_q == T_TO) begin
               err_d   = 1'b1;
               cnt_d   = 2'd0;
               ferr_d  = 1'b0;
               tmr_d   = '0;
               state_d = S_IDLE;
            end else if (byte_done) begin
               tmr_d = '0;
               if (!rx_s_q) ferr_d = 1'b1;
               case (cnt_q)
                  2'd0:    b0_d = rsh_q;
                  2'd1:    b1_d = rsh_q;
                  2'd2:    b2_d = rsh_q;
                  default: b3_d = rsh_q;
               endcase
               if (cnt_q == 2'd3) begin
                  cnt_d   = 2'd0;
                  state_d = S_CHECK;
               end else begin
                  cnt_d   = cnt_q + 2'd1;
                  state_d = S_RXCOL;
               end
            end else if (cnt_q != 2'd0 && !rcv_q) begin
               tmr_d = tmr_q + T_ONE;
            end
         end
         S_CHECK: begin
            state_d = S_IDLE;
            ferr_d  = 1'b0;
            if (ferr_q) begin
               err_d = 1'b1;
            end else if (b0_q != myAddr && b0_q != 8'hFF) begin
               err_d = 1'b0;
            end else if (b3_q != (b0_q ^ b1_q ^ b2_q)) begin
               err_d = 1'b1;
            end else begin
               rv_d  = 1'b1;
               cmd_d = b1_q;
               if (b0_q != 8'hFF) begin
                  busy_d  = 1'b1;
                  tmr_d   = '0;
                  state_d = S_TURN;
               end
            end
         end
         S_TURN: begin
            tmr_d = tmr_q + T_ONE;
            if (tmr_q == T_TURN) begin
               tmr_d   = '0;
               dir_d   = 1'b1;
               k_d     = '0;
               ck_d    = '0;
               state_d = S_PRE;
            end
         end
         S_PRE: begin
            tmr_d = tmr_q + T_ONE;
            if (tmr_q == T_BIT) begin
               tmr_d    = '0;
               rdaddr_d = b2_q;
               state_d  = S_LOAD;
            end
         end
         S_LOAD: begin
            tmr_d = tmr_q + T_ONE;
            if (tmr_q == T_LOAD) begin
               tmr_d   = '0;
               tx_d    = 1'b0;
               nb_d    = '0;
               state_d = S_SHIFT;
               if (k_q == K_LAST) begin
                  sh_d = {1'b1, ck_q};
               end else begin
                  sh_d = {1'b1, rdData};
                  ck_d = ck_q ^ rdData;
               end
            end
         end
         S_SHIFT: begin
            tmr_d = tmr_q + T_ONE;
            if (tmr_q == T_BIT) begin
               tmr_d = '0;
               nb_d  = nb_q + 4'd1;
               if (nb_q == 4'd9) begin
                  tx_d = 1'b1;
                  if (k_q == K_LAST) begin
                     state_d = S_POST;
                  end else begin
                     k_d     = k_q + 5'd1;
                     state_d = S_LOAD;
                     if (k_q + 5'd1 < K_LAST) rdaddr_d = b2_q + {3'b000, k_q} + 8'd1;
                  end
               end else begin
                  tx_d = sh_q[0];
                  sh_d = {1'b0, sh_q[8:1]};
               end
            end
         end
         default: begin
            tmr_d = tmr_q + T_ONE;
            if (tmr_q == T_BIT) begin
               tmr_d   = '0;
               dir_d   = 1'b0;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         tmr_q    <= '0;
         b0_q     <= '0;
         b1_q     <= '0;
         b2_q     <= '0;
         b3_q     <= '0;
         ferr_q   <= 1'b0;
         k_q      <= '0;
         ck_q     <= '0;
         sh_q     <= '0;
         nb_q     <= '0;
         tx_q     <= 1'b1;
         dir_q    <= 1'b0;
         busy_q   <= 1'b0;
         rdaddr_q <= '0;
         cmd_q    <= '0;
         rv_q     <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         tmr_q    <= tmr_d;
         b0_q     <= b0_d;
         b1_q     <= b1_d;
         b2_q     <= b2_d;
         b3_q     <= b3_d;
         ferr_q   <= ferr_d;
         k_q      <= k_d;
         ck_q     <= ck_d;
         sh_q     <= sh_d;
         nb_q     <= nb_d;
         tx_q     <= tx_d;
         dir_q    <= dir_d;
         busy_q   <= busy_d;
         rdaddr_q <= rdaddr_d;
         cmd_q    <= cmd_d;
         rv_q     <= rv_d;
         err_q    <= err_d;
      end
   end

   assign tx       = tx_q;
   assign dirTX    = dir_q;
   assign dirRX    = dir_q;
   assign rdAddr   = rdaddr_q;
   assign reqValid = rv_q;
   assign reqCmd   = cmd_q;
   assign errFlag  = err_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_lcb_responder.sv
// Directed + randomized bench for lcb_responder; a line-level monitor decodes the
// reply and a request-level model predicts pulses, bytes and timing.
module tb_lcb_responder;

   localparam int B     = 16;
   localparam int ANS   = 2;
   localparam int TURN  = 32;
   localparam int TO    = 256;
   localparam int TOTAL = (ANS + 1) * (10 * B + 3) + 2 * B;
   localparam logic [7:0] MY = 8'h05;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rx  = 1'b1;
   logic [7:0] rdData = 8'h00;
   logic [7:0] mem1 = 8'h00;
   logic tx, dirTX, dirRX, reqValid, errFlag, busy;
   logic [7:0] rdAddr, reqCmd;

   lcb_responder #(.BIT_CYCLES(B), .ANS_BYTES(ANS), .TURN_CYCLES(TURN), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .rx(rx), .myAddr(MY), .rdData(rdData),
      .tx(tx), .dirTX(dirTX), .dirRX(dirRX), .rdAddr(rdAddr),
      .reqValid(reqValid), .reqCmd(reqCmd), .errFlag(errFlag), .busy(busy)
   );

   always #5 clk = ~clk;

   // sample store returns ~addr, two clocks after the address changes
   always @(posedge clk) begin
      mem1   <= ~rdAddr;
      rdData <= mem1;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int rv_cnt = 0, er_cnt = 0, rv_cyc = 0, er_cyc = 0, dir_n = 0, dr_bad = 0, stop_err = 0;
   int rise_cyc = 0, rise_delay = 0, dir_len = 0, start_delay = 0, busy_cyc = 0, busy_len = 0;
   int dec_ph = 0;
   logic dec_on = 1'b0, first_pending = 1'b0;
   logic prev_tx = 1'b1, prev_dir = 1'b0, prev_busy = 1'b0;
   logic [7:0] dec_sh = 8'h00;
   logic [7:0] txb[$];
   logic [7:0] adr[$];

   always @(negedge clk) begin
      prev_tx   <= tx;
      prev_dir  <= dirTX;
      prev_busy <= busy;
      if (dirRX !== dirTX) dr_bad <= dr_bad + 1;
      if (reqValid) begin rv_cnt <= rv_cnt + 1; rv_cyc <= cyc; end
      if (errFlag) begin er_cnt <= er_cnt + 1; er_cyc <= cyc; end
      if (dirTX && !prev_dir) begin
         rise_cyc <= cyc; rise_delay <= cyc - rv_cyc; dir_n <= dir_n + 1; first_pending <= 1'b1;
      end
      if (!dirTX && prev_dir && !rst) dir_len <= cyc - rise_cyc;
      if (busy && !prev_busy) busy_cyc <= cyc;
      if (!busy && prev_busy && !rst) busy_len <= cyc - busy_cyc;
      if (rst) begin
         dec_on <= 1'b0;
      end else if (!dec_on) begin
         if (dirTX && prev_tx && !tx) begin
            dec_on <= 1'b1;
            dec_ph <= 1;
            adr.push_back(rdAddr);
            if (first_pending) begin start_delay <= cyc - rise_cyc; first_pending <= 1'b0; end
         end
      end else begin
         dec_ph <= dec_ph + 1;
         if (dec_ph % B == B / 2 && dec_ph >= B) begin
            if (dec_ph / B <= 8) dec_sh <= {tx, dec_sh[7:1]};
            else begin
               txb.push_back(dec_sh);
               if (!tx) stop_err <= stop_err + 1;
               dec_on <= 1'b0;
            end
         end
      end
   end

   int nchk = 0, nerr = 0;
   logic [7:0] exp_cmd = 8'h00;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rx = 1'b0; tick(B);
      for (int i = 0; i < 8; i++) begin rx = b[i]; tick(B); end
      rx = stop_bit; tick(B);
      rx = 1'b1; tick(4);
   endtask

   // 0 = silent, 1 = error, 2 = broadcast accepted, 3 = accepted with reply
   function automatic int classify(input logic [7:0] a, c, ch, ck);
      if (a != MY && a != 8'hFF) return 0;
      if (ck != (a ^ c ^ ch)) return 1;
      return (a == 8'hFF) ? 2 : 3;
   endfunction

   task automatic run_req(input string nm, input logic [7:0] a, c, ch, ck, input logic [3:0] badstop);
      int rv0, er0, tb0, ad0, dn0, kind;
      logic [7:0] x, e, ea;
      logic [7:0] req[4];
      rv0 = rv_cnt; er0 = er_cnt; tb0 = txb.size(); ad0 = adr.size(); dn0 = dir_n;
      req[0] = a; req[1] = c; req[2] = ch; req[3] = ck;
      kind = (badstop != 4'd0) ? 1 : classify(a, c, ch, ck);
      for (int i = 0; i < 4; i++) send_byte(req[i], ~badstop[i]);
      tick(TURN + TOTAL + 60);
      if (kind >= 2) exp_cmd = c;
      chk($sformatf("%s.reqValid", nm), rv_cnt - rv0, (kind >= 2) ? 1 : 0);
      chk($sformatf("%s.errFlag", nm), er_cnt - er0, (kind == 1) ? 1 : 0);
      chk($sformatf("%s.reqCmd", nm), reqCmd, exp_cmd);
      chk($sformatf("%s.nbytes", nm), txb.size() - tb0, (kind == 3) ? ANS + 1 : 0);
      chk($sformatf("%s.dirRise", nm), dir_n - dn0, (kind == 3) ? 1 : 0);
      if (kind == 3 && txb.size() >= tb0 + ANS + 1 && adr.size() >= ad0 + ANS + 1) begin
         x = 8'h00;
         for (int k = 0; k < ANS; k++) begin
            ea = ch + 8'(k);
            e  = ~ea;
            x  = x ^ e;
            chk($sformatf("%s.byte%0d", nm, k), txb[tb0 + k], e);
            chk($sformatf("%s.rdAddr%0d", nm, k), adr[ad0 + k], ea);
         end
         ea = ch + 8'(ANS - 1);
         chk($sformatf("%s.cksum", nm), txb[tb0 + ANS], x);
         chk($sformatf("%s.rdAddrCk", nm), adr[ad0 + ANS], ea);
         chk($sformatf("%s.turnDelay", nm), rise_delay, TURN);
         chk($sformatf("%s.dirLen", nm), dir_len, TOTAL);
         chk($sformatf("%s.startDelay", nm), start_delay, B + 3);
         chk($sformatf("%s.busyLen", nm), busy_len, TURN + TOTAL);
      end
   endtask

   initial begin
      int er0, rv0, ad0, endc, w, pick;
      logic [7:0] a, c, ch, ck;
      rst = 1'b1; rx = 1'b1;
      tick(3);
      chk("rst.tx", tx, 1);
      chk("rst.dirTX", dirTX, 0);
      chk("rst.dirRX", dirRX, 0);
      chk("rst.rdAddr", rdAddr, 0);
      chk("rst.reqCmd", reqCmd, 0);
      chk("rst.reqValid", reqValid, 0);
      chk("rst.errFlag", errFlag, 0);
      chk("rst.busy", busy, 0);
      rst = 1'b0;
      tick(5);

      run_req("valid", 8'h05, 8'h01, 8'h10, 8'h14, 4'b0000);
      run_req("badck", 8'h05, 8'h01, 8'h10, 8'h15, 4'b0000);
      run_req("wrongaddr", 8'h06, 8'h01, 8'h10, 8'h17, 4'b0000);
      run_req("bcast", 8'hFF, 8'h02, 8'h00, 8'hFD, 4'b0000);

      // two bytes then silence: one timeout error, no request
      er0 = er_cnt; rv0 = rv_cnt;
      send_byte(8'h05, 1'b1);
      send_byte(8'h01, 1'b1);
      endc = cyc - 4;
      tick(300);
      chk("tmo.errFlag", er_cnt - er0, 1);
      chk("tmo.reqValid", rv_cnt - rv0, 0);
      chk("tmo.window", ((er_cyc - endc) >= TO - B / 2 - 4 && (er_cyc - endc) <= TO), 1);
      run_req("aftertmo", 8'h05, 8'h01, 8'h10, 8'h14, 4'b0000);

      run_req("framing", 8'h05, 8'h01, 8'h10, 8'h14, 4'b0010);
      run_req("wrap", 8'h05, 8'h03, 8'hFF, 8'h05 ^ 8'h03 ^ 8'hFF, 4'b0000);

      for (int i = 0; i < 6; i++) begin
         pick = $urandom_range(0, 3);
         a  = (pick <= 1) ? MY : (pick == 2) ? 8'hFF : 8'($urandom);
         c  = 8'($urandom);
         ch = 8'($urandom);
         ck = a ^ c ^ ch;
         if ($urandom_range(0, 3) == 0) ck = ck ^ (8'd1 << $urandom_range(0, 7));
         run_req($sformatf("rand%0d", i), a, c, ch, ck, 4'b0000);
      end

      // reset while the second data byte is on the wire
      ad0 = adr.size();
      send_byte(8'h05, 1'b1);
      send_byte(8'h07, 1'b1);
      send_byte(8'h20, 1'b1);
      send_byte(8'h05 ^ 8'h07 ^ 8'h20, 1'b1);
      w = 0;
      while (adr.size() < ad0 + 2 && w < 2000) begin tick(1); w++; end
      chk("midrst.reached", adr.size() >= ad0 + 2, 1);
      tick(20);
      chk("midrst.pre_dirTX", dirTX, 1);
      rst = 1'b1;
      #1;
      chk("midrst.tx", tx, 1);
      chk("midrst.dirTX", dirTX, 0);
      chk("midrst.dirRX", dirRX, 0);
      chk("midrst.busy", busy, 0);
      exp_cmd = 8'h00;
      tick(3);
      rst = 1'b0;
      tick(5);
      run_req("afterrst", 8'h05, 8'h09, 8'h40, 8'h05 ^ 8'h09 ^ 8'h40, 4'b0000);

      // partial request discarded by reset
      send_byte(8'h05, 1'b1);
      send_byte(8'h01, 1'b1);
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      exp_cmd = 8'h00;
      tick(5);
      run_req("partial", 8'h05, 8'h0A, 8'h33, 8'h05 ^ 8'h0A ^ 8'h33, 4'b0000);

      chk("dirRX_eq_dirTX", dr_bad, 0);
      chk("tx_stop_bits", stop_err, 0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
